// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle shared by the two requesters, the memory bus arbiter and the
// external memory port.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
);
    logic                  r0Req;
    logic                  r0Write;
    logic [ADDR_WIDTH-1:0] r0Addr;
    logic [DATA_WIDTH-1:0] r0WData;
    logic                  r0Ack;
    logic                  r1Req;
    logic                  r1Write;
    logic [ADDR_WIDTH-1:0] r1Addr;
    logic [DATA_WIDTH-1:0] r1WData;
    logic                  r1Ack;
    logic [DATA_WIDTH-1:0] rData;
    logic                  busy;
    logic                  memWriteReq;
    logic [ADDR_WIDTH-1:0] memReqBus;
    logic [DATA_WIDTH-1:0] read_data;

    modport slave (
        input  r0Req, r0Write, r0Addr, r0WData,
        input  r1Req, r1Write, r1Addr, r1WData,
        input  read_data,
        output r0Ack, r1Ack, rData, busy, memWriteReq, memReqBus
    );

    modport master (
        output r0Req, r0Write, r0Addr, r0WData,
        output r1Req, r1Write, r1Addr, r1WData,
        output read_data,
        input  r0Ack, r1Ack, rData, busy, memWriteReq, memReqBus
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one multiplexed memory request bus between the
// instruction-fetch port (0) and the data port (1); one transaction in flight.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_RDATA = 3'd2,
        ST_WDATA = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_r, state_next_s;
    logic                  last_grant_r, last_grant_next_s;
    logic                  grant_r, grant_next_s;
    logic                  write_r, write_next_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_next_s;
    logic [DATA_WIDTH-1:0] wdata_r, wdata_next_s;
    logic [ADDR_WIDTH-1:0] wdata_ext_s;
    logic [ADDR_WIDTH-1:0] bus_r, bus_next_s;
    logic                  wr_r, wr_next_s;
    logic                  ack0_r, ack0_next_s;
    logic                  ack1_r, ack1_next_s;
    logic                  busy_r, busy_next_s;
    logic [DATA_WIDTH-1:0] rdata_r;

    // Next-state, arbitration and request latching
    always_comb begin
        state_next_s      = state_r;
        last_grant_next_s = last_grant_r;
        grant_next_s      = grant_r;
        write_next_s      = write_r;
        addr_next_s       = addr_r;
        wdata_next_s      = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.r0Req || bus.r1Req) begin
                    // On a tie the port that did not win last time goes next
                    if (bus.r0Req && bus.r1Req) begin
                        grant_next_s = ~last_grant_r;
                    end else if (bus.r0Req) begin
                        grant_next_s = 1'b0;
                    end else begin
                        grant_next_s = 1'b1;
                    end
                    last_grant_next_s = grant_next_s;
                    if (grant_next_s) begin
                        write_next_s = bus.r1Write;
                        addr_next_s  = bus.r1Addr;
                        wdata_next_s = bus.r1WData;
                    end else begin
                        write_next_s = bus.r0Write;
                        addr_next_s  = bus.r0Addr;
                        wdata_next_s = bus.r0WData;
                    end
                    state_next_s = ST_ADDR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADDR:  state_next_s = write_r ? ST_WDATA : ST_RDATA;
            ST_RDATA: state_next_s = ST_DONE;
            ST_WDATA: state_next_s = ST_DONE;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Write data zero-extended onto the address-wide bus
    always_comb begin
        wdata_ext_s                 = {ADDR_WIDTH{1'b0}};
        wdata_ext_s[DATA_WIDTH-1:0] = wdata_next_s;
    end

    // Bus/ack values for the upcoming state, so the outputs can be registered
    always_comb begin
        bus_next_s  = {ADDR_WIDTH{1'b0}};
        wr_next_s   = 1'b0;
        ack0_next_s = 1'b0;
        ack1_next_s = 1'b0;
        busy_next_s = (state_next_s != ST_IDLE);
        case (state_next_s)
            ST_IDLE: begin
                bus_next_s = {ADDR_WIDTH{1'b0}};
            end
            ST_ADDR: begin
                bus_next_s = addr_next_s;
                wr_next_s  = write_next_s;
            end
            ST_RDATA: begin
                bus_next_s = addr_next_s;
            end
            ST_WDATA: begin
                bus_next_s = wdata_ext_s;
                wr_next_s  = 1'b1;
            end
            ST_DONE: begin
                ack0_next_s = ~grant_next_s;
                ack1_next_s = grant_next_s;
            end
            default: begin
                bus_next_s = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // State, latched request fields and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            grant_r      <= 1'b0;
            write_r      <= 1'b0;
            addr_r       <= {ADDR_WIDTH{1'b0}};
            wdata_r      <= {DATA_WIDTH{1'b0}};
            bus_r        <= {ADDR_WIDTH{1'b0}};
            wr_r         <= 1'b0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            last_grant_r <= last_grant_next_s;
            grant_r      <= grant_next_s;
            write_r      <= write_next_s;
            addr_r       <= addr_next_s;
            wdata_r      <= wdata_next_s;
            bus_r        <= bus_next_s;
            wr_r         <= wr_next_s;
            ack0_r       <= ack0_next_s;
            ack1_r       <= ack1_next_s;
            busy_r       <= busy_next_s;
        end
    end

    // Read data is the memory word answering the address cycle; held otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (state_r == ST_RDATA) begin
            rdata_r <= bus.read_data;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign bus.memReqBus   = bus_r;
    assign bus.memWriteReq = wr_r;
    assign bus.r0Ack       = ack0_r;
    assign bus.r1Ack       = ack1_r;
    assign bus.busy        = busy_r;
    assign bus.rData       = rdata_r;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, randomized
// transactions against a memory/arbitration reference model, and corner sequences.
module tb_mem_bus_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();
    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory behaving like SimpleMemory: reads answer the previous cycle's address,
    // writes are an address beat followed by a data beat.
    logic [7:0]  mem [0:32767];
    logic        wphase = 1'b0;
    logic [14:0] waddr  = 15'd0;
    logic        pre_we = 1'b0;
    logic [14:0] pre_a  = 15'd0;
    logic [7:0]  pre_d  = 8'd0;
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (bif.memWriteReq) begin
            if (!wphase) begin
                waddr  <= bif.memReqBus;
                wphase <= 1'b1;
            end else begin
                mem[waddr] <= bif.memReqBus[7:0];
                wphase     <= 1'b0;
            end
        end else begin
            wphase        <= 1'b0;
            bif.read_data <= mem[bif.memReqBus];
        end
    end

    // Continuous protocol monitor: acks exclusive, acks only while busy, write beats in pairs
    bit mon_en = 1'b0;
    int wr_run = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            check("ack_exclusive", {31'd0, bif.r0Ack & bif.r1Ack}, 32'd0);
            if (bif.r0Ack || bif.r1Ack) check("ack_while_busy", {31'd0, bif.busy}, 32'd1);
            if (bif.memWriteReq === 1'b1) begin
                wr_run++;
            end else begin
                if (wr_run != 0) check("write_beat_pair", wr_run, 32'd2);
                wr_run = 0;
            end
        end
    end

    // Reference model: memory contents, last read value, last served port
    logic [7:0]  model_mem [logic [14:0]];
    logic [14:0] addr_q [$];
    logic [7:0]  last_read  = 8'd0;
    bit          model_last = 1'b1;

    task automatic drive_port(input bit port, input bit req, input bit wr,
                              input logic [14:0] addr, input logic [7:0] wdata);
        if (port) begin
            bif.r1Req = req; bif.r1Write = wr; bif.r1Addr = addr; bif.r1WData = wdata;
        end else begin
            bif.r0Req = req; bif.r0Write = wr; bif.r0Addr = addr; bif.r0WData = wdata;
        end
    endtask

    // One single-requester transaction, cycle-by-cycle against the protocol rules
    task automatic run_txn(input bit port, input bit wr, input logic [14:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_rd, input string nm);
        logic [14:0] exp_bus [3];
        logic        exp_wr  [3];
        exp_bus[0] = addr;                        exp_wr[0] = wr;
        exp_bus[1] = wr ? {7'd0, wdata} : addr;   exp_wr[1] = wr;
        exp_bus[2] = 15'd0;                       exp_wr[2] = 1'b0;
        @(negedge clk);
        drive_port(port, 1'b1, wr, addr, wdata);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check({nm, "_bus"},  {17'd0, bif.memReqBus}, {17'd0, exp_bus[k]});
            check({nm, "_wr"},   {31'd0, bif.memWriteReq}, {31'd0, exp_wr[k]});
            check({nm, "_busy"}, {31'd0, bif.busy}, 32'd1);
            check({nm, "_ack0"}, {31'd0, bif.r0Ack}, {31'd0, (k == 2) && !port});
            check({nm, "_ack1"}, {31'd0, bif.r1Ack}, {31'd0, (k == 2) && port});
        end
        check({nm, "_rdata"}, {24'd0, bif.rData}, {24'd0, exp_rd});
        @(negedge clk);
        drive_port(port, 1'b0, 1'b0, 15'd0, 8'd0);
        if (wr) begin
            model_mem[addr] = wdata;
            addr_q.push_back(addr);
        end else begin
            last_read = exp_rd;
        end
        model_last = port;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_port(1'b0, 1'b0, 1'b0, 15'd0, 8'd0);
        drive_port(1'b1, 1'b0, 1'b0, 15'd0, 8'd0);
        @(negedge clk);
        reset      = 1'b0;
        model_last = 1'b1;
        last_read  = 8'd0;
    endtask

    typedef struct {
        bit          port;
        bit          wr;
        logic [14:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
    } vec_t;
    vec_t tbl [7];

    initial begin
        bit          rp, rw, got, exp_port;
        logic [14:0] ra;
        logic [7:0]  rd, exp_rd;
        int          cyc;

        tbl[0] = '{1'b0, 1'b0, 15'h1234, 8'h00, 8'hA5};
        tbl[1] = '{1'b1, 1'b1, 15'h7FFF, 8'h3C, 8'hA5};
        tbl[2] = '{1'b0, 1'b0, 15'h7FFF, 8'h00, 8'h3C};
        tbl[3] = '{1'b0, 1'b1, 15'h0010, 8'h11, 8'h3C};
        tbl[4] = '{1'b0, 1'b1, 15'h0011, 8'h22, 8'h3C};
        tbl[5] = '{1'b0, 1'b0, 15'h0010, 8'h00, 8'h11};
        tbl[6] = '{1'b1, 1'b0, 15'h0011, 8'h00, 8'h22};

        reset = 1'b1;
        drive_port(1'b0, 1'b0, 1'b0, 15'd0, 8'd0);
        drive_port(1'b1, 1'b0, 1'b0, 15'd0, 8'd0);
        repeat (3) @(negedge clk);
        pre_we = 1'b1; pre_a = 15'h1234; pre_d = 8'hA5;
        @(negedge clk);
        pre_we = 1'b0;
        model_mem[15'h1234] = 8'hA5;
        addr_q.push_back(15'h1234);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Reset values and quiet bus with no requests
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("idle_bus",   {17'd0, bif.memReqBus}, 32'd0);
            check("idle_wr",    {31'd0, bif.memWriteReq}, 32'd0);
            check("idle_busy",  {31'd0, bif.busy}, 32'd0);
            check("idle_acks",  {30'd0, bif.r1Ack, bif.r0Ack}, 32'd0);
            check("idle_rdata", {24'd0, bif.rData}, 32'd0);
        end

        for (int i = 0; i < 7; i++)
            run_txn(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, "vec");

        // Randomized transactions; reads only hit addresses the model knows
        for (int i = 0; i < 24; i++) begin
            rp = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            rd = 8'($urandom_range(0, 255));
            if (rw) ra = 15'h2000 + 15'($urandom_range(0, 16383));
            else    ra = addr_q[$urandom_range(0, addr_q.size() - 1)];
            exp_rd = rw ? last_read : model_mem[ra];
            run_txn(rp, rw, ra, rd, exp_rd, "rnd");
        end

        // Both ports held: strict alternation starting with port 0 after reset
        do_reset();
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b0, 15'h1234, 8'd0);
        drive_port(1'b1, 1'b1, 1'b0, 15'h7FFF, 8'd0);
        for (int n = 0; n < 4; n++) begin
            exp_port = ~model_last;
            got = 1'b0;
            cyc = 0;
            while (!got && cyc < 8) begin
                @(posedge clk); #1;
                cyc++;
                got = bif.r0Ack || bif.r1Ack;
            end
            check("rr_ack_seen", {31'd0, got}, 32'd1);
            check("rr_gap",      cyc, (n == 0) ? 32'd3 : 32'd4);
            check("rr_port",     {31'd0, bif.r1Ack}, {31'd0, exp_port});
            check("rr_rdata",    {24'd0, bif.rData}, exp_port ? 32'h3C : 32'hA5);
            model_last = exp_port;
        end
        @(negedge clk);
        drive_port(1'b0, 1'b0, 1'b0, 15'd0, 8'd0);
        drive_port(1'b1, 1'b0, 1'b0, 15'd0, 8'd0);

        // Reset while port 0's write is on its data beat
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b1, 15'h0100, 8'h77);
        @(posedge clk); #1;
        check("abort_addr_beat", {16'd0, bif.memWriteReq, bif.memReqBus}, {16'd0, 1'b1, 15'h0100});
        @(posedge clk); #1;
        check("abort_data_beat", {16'd0, bif.memWriteReq, bif.memReqBus}, {16'd0, 1'b1, 15'h0077});
        @(negedge clk);
        reset = 1'b1;
        drive_port(1'b0, 1'b0, 1'b0, 15'd0, 8'd0);
        @(posedge clk); #1;
        check("abort_wr",   {31'd0, bif.memWriteReq}, 32'd0);
        check("abort_bus",  {17'd0, bif.memReqBus}, 32'd0);
        check("abort_busy", {31'd0, bif.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_ack", {30'd0, bif.r1Ack, bif.r0Ack}, 32'd0);
        end
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b0, 15'h0010, 8'd0);
        drive_port(1'b1, 1'b1, 1'b0, 15'h0011, 8'd0);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
            got = bif.r0Ack || bif.r1Ack;
        end
        check("post_reset_seen",  {31'd0, got}, 32'd1);
        check("post_reset_first", {30'd0, bif.r1Ack, bif.r0Ack}, 32'd1);
        check("post_reset_rdata", {24'd0, bif.rData}, 32'h11);
        @(negedge clk);
        drive_port(1'b0, 1'b0, 1'b0, 15'd0, 8'd0);
        drive_port(1'b1, 1'b0, 1'b0, 15'd0, 8'd0);
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
